// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: D-stage decode, E/M/W control pipeline, Tuse/Tnew hazard stall and mult/div busy tracking
module pipe_ctrl_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  output logic        stall,
  output logic        ext_sel_D,
  output logic [1:0]  cmp_op_D,
  output logic [1:0]  npc_sel_D,
  output logic [3:0]  alu_op_E,
  output logic        alu_src_E,
  output logic [2:0]  md_op_E,
  output logic        md_start_E,
  output logic        md_busy,
  output logic        dm_we_M,
  output logic        dm_re_M,
  output logic        rf_we_W,
  output logic [4:0]  rf_a3_W,
  output logic [1:0]  rf_wd_sel_W
);
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic [2:0] md_op;
    logic       dm_we;
    logic       dm_re;
    logic       rf_we;
    logic [4:0] a3;
    logic [1:0] wd_sel;
    logic [1:0] tnew;
  } e_t;
  typedef struct packed {
    logic       dm_we;
    logic       dm_re;
    logic       rf_we;
    logic [4:0] a3;
    logic [1:0] wd_sel;
    logic [1:0] tnew;
  } m_t;
  typedef struct packed {
    logic       rf_we;
    logic [4:0] a3;
    logic [1:0] wd_sel;
  } w_t;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic [1:0] tuse_rs, tuse_rt;
  logic       md_d, hz_rs, hz_rt, unused_shamt;
  e_t         dec, e_d, e_q;
  m_t         m_d, m_q;
  w_t         w_d, w_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign op = instr_D[31:26];
  assign rs = instr_D[25:21];
  assign rt = instr_D[20:16];
  assign rd = instr_D[15:11];
  assign fn = instr_D[5:0];
  assign unused_shamt = ^instr_D[10:6];
  // decode the D instruction into its E control word, D-stage selects and operand Tuse (3 = not read)
  always_comb begin
    dec       = '0;
    md_d      = 1'b0;
    tuse_rs   = 2'd3;
    tuse_rt   = 2'd3;
    ext_sel_D = 1'b0;
    cmp_op_D  = 2'd0;
    npc_sel_D = 2'd0;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: begin dec.alu_op = 4'd0; dec.a3 = rd; dec.tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
        6'h22, 6'h23: begin dec.alu_op = 4'd1; dec.a3 = rd; dec.tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
        6'h24:        begin dec.alu_op = 4'd2; dec.a3 = rd; dec.tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
        6'h25:        begin dec.alu_op = 4'd3; dec.a3 = rd; dec.tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
        6'h2a:        begin dec.alu_op = 4'd5; dec.a3 = rd; dec.tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
        6'h2b:        begin dec.alu_op = 4'd6; dec.a3 = rd; dec.tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1; end
        6'h08:        begin npc_sel_D = 2'd3; tuse_rs = 2'd0; end
        6'h10, 6'h12: begin dec.a3 = rd; dec.tnew = 2'd1; dec.wd_sel = 2'd3; md_d = 1'b1; end
        6'h11, 6'h13: begin dec.md_op = fn[1] ? 3'd6 : 3'd5; tuse_rs = 2'd1; md_d = 1'b1; end
        6'h18, 6'h19, 6'h1a, 6'h1b: begin
          dec.md_op = 3'({1'b0, fn[1:0]}) + 3'd1;
          tuse_rs   = 2'd1;
          tuse_rt   = 2'd1;
          md_d      = 1'b1;
        end
        default: ;
      endcase
      6'h0d: begin dec.alu_op = 4'd3; dec.alu_src = 1'b1; dec.a3 = rt; dec.tnew = 2'd1; tuse_rs = 2'd1; ext_sel_D = 1'b1; end
      6'h0f: begin dec.alu_op = 4'd4; dec.alu_src = 1'b1; dec.a3 = rt; dec.tnew = 2'd1; end
      6'h23: begin dec.alu_src = 1'b1; dec.dm_re = 1'b1; dec.a3 = rt; dec.tnew = 2'd2; dec.wd_sel = 2'd1; tuse_rs = 2'd1; end
      6'h2b: begin dec.alu_src = 1'b1; dec.dm_we = 1'b1; tuse_rs = 2'd1; tuse_rt = 2'd2; end
      6'h04, 6'h05: begin cmp_op_D = op[0] ? 2'd2 : 2'd1; npc_sel_D = 2'd1; tuse_rs = 2'd0; tuse_rt = 2'd0; end
      6'h03: begin npc_sel_D = 2'd2; dec.a3 = 5'd31; dec.wd_sel = 2'd2; end
      default: ;
    endcase
    dec.rf_we = |dec.a3;
  end
  assign hz_rs = rs != 5'd0 && ((rs == e_q.a3 && e_q.tnew > tuse_rs) || (rs == m_q.a3 && m_q.tnew > tuse_rs));
  assign hz_rt = rt != 5'd0 && ((rt == e_q.a3 && e_q.tnew > tuse_rt) || (rt == m_q.a3 && m_q.tnew > tuse_rt));
  assign stall = hz_rs || hz_rt || (md_d && (md_busy || md_start_E));
  // next-state of the control pipeline: bubble into E on stall, tnew ages one step per stage
  always_comb begin
    e_d = stall ? '0 : dec;
    m_d = '{dm_we: e_q.dm_we, dm_re: e_q.dm_re, rf_we: e_q.rf_we, a3: e_q.a3,
            wd_sel: e_q.wd_sel, tnew: e_q.tnew - {1'b0, |e_q.tnew}};
    w_d = '{rf_we: m_q.rf_we, a3: m_q.a3, wd_sel: m_q.wd_sel};
    cnt_d = md_start_E ? ((md_op_E <= 3'd2) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES))
                       : cnt_q - CNT_W'(md_busy);
  end
  // pipeline registers and busy counter; reset clears everything to the nop word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end
  assign alu_op_E    = e_q.alu_op;
  assign alu_src_E   = e_q.alu_src;
  assign md_op_E     = e_q.md_op;
  assign md_start_E  = e_q.md_op != 3'd0 && e_q.md_op <= 3'd4;
  assign md_busy     = |cnt_q;
  assign dm_we_M     = m_q.dm_we;
  assign dm_re_M     = m_q.dm_re;
  assign rf_we_W     = w_q.rf_we && |w_q.a3;
  assign rf_a3_W     = w_q.a3;
  assign rf_wd_sel_W = w_q.wd_sel;
endmodule
